unified_mem_arbiter: RTL and testbench

Sits directly upstream of the single-port, byte-addressable 16-bit memory (combinational read, write on rising clk, no concurrent read/write). It multiplexes the fetch-stage instruction port and the memory-stage data port onto that one memory port, one access per cycle. It registers the responses, flags unaligned word accesses, and sequences the end-of-program memory dump on halt.

---
 rtl/unified_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port 16-bit memory between the fetch and data ports.
// Also registers the responses and runs the halt -> dump -> halted sequence.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  input  logic        halt,
  output logic        if_gnt,
  output logic        dm_gnt,
  output logic        if_done,
  output logic [15:0] if_rdata,
  output logic        if_err,
  output logic        dm_done,
  output logic [15:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_dump,
  input  logic [15:0] mem_rdata,
  output logic        halted
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [1:0] {RUN, DUMP, HALTED} state_e;

  state_e      state_q, state_d;
  logic [7:0]  starve_q, starve_d;
  logic        if_done_q, if_done_d, if_err_q, if_err_d;
  logic        dm_done_q, dm_done_d, dm_err_q, dm_err_d;
  logic [15:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

  logic        grant;
  logic [15:0] sel_addr;
  logic        aligned;

  always_comb begin
    state_d  = state_q;
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    mem_dump = 1'b0;
    case (state_q)
      RUN: begin
        // A pending data access is served before halt takes effect.
        if (halt && !dm_req) begin
          state_d = DUMP;
        end else if (dm_req && (!if_req || halt || starve_q != STARVE_LIM)) begin
          dm_gnt = 1'b1;
        end else if (if_req) begin
          if_gnt = 1'b1;
        end
      end
      DUMP: begin
        mem_dump = 1'b1;
        state_d  = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (rst) begin
      if_gnt   = 1'b0;
      dm_gnt   = 1'b0;
      mem_dump = 1'b0;
    end
  end

  assign grant     = if_gnt | dm_gnt;
  assign sel_addr  = if_gnt ? if_addr : dm_addr;
  assign aligned   = ~sel_addr[0];
  assign mem_en    = grant & aligned;
  assign mem_wr    = mem_en & dm_gnt & dm_wr;
  assign mem_addr  = mem_en ? sel_addr : 16'h0000;
  assign mem_wdata = (mem_en & dm_gnt) ? dm_wdata : 16'h0000;

  always_comb begin
    starve_d = 8'd0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q == 8'hFF) ? starve_q : starve_q + 8'd1;
    end
  end

  // Unaligned accesses and writes complete with zero read data.
  always_comb begin
    if_done_d  = if_gnt;
    if_err_d   = if_gnt & sel_addr[0];
    if_rdata_d = if_rdata_q;
    if (if_gnt) begin
      if_rdata_d = aligned ? mem_rdata : 16'h0000;
    end
    dm_done_d  = dm_gnt;
    dm_err_d   = dm_gnt & sel_addr[0];
    dm_rdata_d = dm_rdata_q;
    if (dm_gnt) begin
      dm_rdata_d = (aligned && !dm_wr) ? mem_rdata : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      starve_q   <= 8'd0;
      if_done_q  <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= 16'h0000;
      dm_done_q  <= 1'b0;
      dm_err_q   <= 1'b0;
      dm_rdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      if_done_q  <= if_done_d;
      if_err_q   <= if_err_d;
      if_rdata_q <= if_rdata_d;
      dm_done_q  <= dm_done_d;
      dm_err_q   <= dm_err_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_err   = if_err_q;
  assign if_rdata = if_rdata_q;
  assign dm_done  = dm_done_q;
  assign dm_err   = dm_err_q;
  assign dm_rdata = dm_rdata_q;
  assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a byte memory behind the port,
// a spec-level reference model checked every cycle, plus literal spot checks.
module tb_unified_mem_arbiter;

  localparam int SMAX = 3;
  localparam int TN   = 512;

  logic        clk = 1'b0;
  logic        rst, if_req, dm_req, dm_wr, halt;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_gnt, dm_gnt, if_done, if_err, dm_done, dm_err;
  logic [15:0] if_rdata, dm_rdata;
  logic        mem_en, mem_wr, mem_dump, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .halt(halt),
    .if_gnt(if_gnt), .dm_gnt(dm_gnt),
    .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_dump(mem_dump), .mem_rdata(mem_rdata), .halted(halted)
  );

  // Byte-addressed big-endian memory (low 256 bytes populated).
  logic [7:0] env_mem [0:255];
  assign mem_rdata = {env_mem[mem_addr[7:0]], env_mem[mem_addr[7:0] + 8'd1]};
  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      env_mem[mem_addr[7:0]]        <= mem_wdata[15:8];
      env_mem[mem_addr[7:0] + 8'd1] <= mem_wdata[7:0];
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle trace of DUT outputs for literal checks.
  logic        t_ifg [0:TN-1], t_dmg [0:TN-1], t_en [0:TN-1], t_dump [0:TN-1];
  logic        t_halted [0:TN-1], t_ifd [0:TN-1], t_ife [0:TN-1];
  logic        t_dmd [0:TN-1], t_dme [0:TN-1];
  logic [15:0] t_ifr [0:TN-1], t_dmr [0:TN-1];

  // Reference model: memory as 16-bit words, phase 0=run 1=dump 2=halted.
  logic [15:0] m_word [0:127];
  int          m_phase, m_starve;
  logic        e_ifd, e_ife, e_dmd, e_dme;
  logic [15:0] e_ifr, e_dmr;
  logic        x_ifg, x_dmg, x_en, x_wr, x_dump;
  logic [15:0] x_addr, x_wd, a;

  function automatic logic [7:0] fill(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = fill(i);
    for (int k = 0; k < 128; k++) m_word[k] = {fill(2 * k), fill(2 * k + 1)};
    env_mem[0] = 8'h12;
    env_mem[1] = 8'h34;
    m_word[0]  = 16'h1234;
    m_phase = 0; m_starve = 0;
    e_ifd = 0; e_ife = 0; e_dmd = 0; e_dme = 0; e_ifr = 0; e_dmr = 0;
    forever begin
      @(negedge clk);
      x_ifg = 0; x_dmg = 0; x_dump = 0;
      if (!rst) begin
        if (m_phase == 0) begin
          if (halt && !dm_req) x_ifg = 0;
          else if (if_req && dm_req && !halt) begin
            if (m_starve == SMAX) x_ifg = 1; else x_dmg = 1;
          end
          else if (dm_req) x_dmg = 1;
          else if (if_req) x_ifg = 1;
        end else if (m_phase == 1) x_dump = 1;
      end
      a      = x_ifg ? if_addr : dm_addr;
      x_en   = (x_ifg || x_dmg) && (a % 2 == 0);
      x_wr   = x_en && x_dmg && dm_wr;
      x_addr = x_en ? a : 16'h0000;
      x_wd   = (x_en && x_dmg) ? dm_wdata : 16'h0000;
      if (chk_on) begin
        chk("if_gnt", 16'(if_gnt), 16'(x_ifg));
        chk("dm_gnt", 16'(dm_gnt), 16'(x_dmg));
        chk("mem_en", 16'(mem_en), 16'(x_en));
        chk("mem_wr", 16'(mem_wr), 16'(x_wr));
        chk("mem_addr", mem_addr, x_addr);
        chk("mem_wdata", mem_wdata, x_wd);
        chk("mem_dump", 16'(mem_dump), 16'(x_dump));
        chk("halted", 16'(halted), 16'(m_phase == 2));
        chk("if_done", 16'(if_done), 16'(e_ifd));
        chk("if_rdata", if_rdata, e_ifr);
        chk("if_err", 16'(if_err), 16'(e_ife));
        chk("dm_done", 16'(dm_done), 16'(e_dmd));
        chk("dm_rdata", dm_rdata, e_dmr);
        chk("dm_err", 16'(dm_err), 16'(e_dme));
        chk("one_gnt", 16'(if_gnt & dm_gnt), 16'h0000);
        chk("wr_vs_dump", 16'(mem_en & mem_wr & mem_dump), 16'h0000);
        if (cyc < TN) begin
          t_ifg[cyc] = if_gnt;   t_dmg[cyc] = dm_gnt;   t_en[cyc] = mem_en;
          t_dump[cyc] = mem_dump; t_halted[cyc] = halted;
          t_ifd[cyc] = if_done;  t_ife[cyc] = if_err;   t_ifr[cyc] = if_rdata;
          t_dmd[cyc] = dm_done;  t_dme[cyc] = dm_err;   t_dmr[cyc] = dm_rdata;
        end
      end
      if (rst) begin
        m_phase = 0; m_starve = 0;
        e_ifd = 0; e_ife = 0; e_dmd = 0; e_dme = 0; e_ifr = 0; e_dmr = 0;
      end else begin
        e_ifd = x_ifg;
        e_ife = x_ifg && a[0];
        if (x_ifg) e_ifr = a[0] ? 16'h0000 : m_word[a[7:1]];
        e_dmd = x_dmg;
        e_dme = x_dmg && a[0];
        if (x_dmg) e_dmr = (a[0] || dm_wr) ? 16'h0000 : m_word[a[7:1]];
        if (x_dmg && !a[0] && dm_wr) m_word[a[7:1]] = dm_wdata;
        m_starve = (if_req && !x_ifg) ? ((m_starve < 255) ? m_starve + 1 : 255) : 0;
        if (m_phase == 0 && halt && !dm_req) m_phase = 1;
        else if (m_phase == 1) m_phase = 2;
      end
      cyc++;
    end
  end

  task automatic drv(input logic r, input logic ir, input logic [15:0] ia,
                     input logic dr, input logic dw, input logic [15:0] da,
                     input logic [15:0] dwd, input logic h, output int c);
    rst = r; if_req = ir; if_addr = ia;
    dm_req = dr; dm_wr = dw; dm_addr = da; dm_wdata = dwd; halt = h;
    c = cyc;
    @(posedge clk);
    #1;
  endtask

  int c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, cx;

  initial begin
    rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_wr = 0;
    dm_addr = 0; dm_wdata = 0; halt = 0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    drv(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, c0);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    // Fetch of word 0.
    drv(0, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 0, c1);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    // Data write then read-back.
    drv(0, 0, 16'h0, 1, 1, 16'h0010, 16'hBEEF, 0, c2);
    drv(0, 0, 16'h0, 1, 0, 16'h0010, 16'h0, 0, c3);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    // Contention for six cycles.
    drv(0, 1, 16'h0002, 1, 0, 16'h0004, 16'h0, 0, c4);
    for (int k = 1; k < 6; k++) drv(0, 1, 16'h0002, 1, 0, 16'h0004, 16'h0, 0, cx);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    // Unaligned data then unaligned fetch, fetch reading written word.
    drv(0, 0, 16'h0, 1, 0, 16'h0003, 16'h0, 0, c5);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    drv(0, 1, 16'h0005, 0, 0, 16'h0, 16'h0, 0, cx);
    drv(0, 1, 16'h0010, 0, 0, 16'h0, 16'h0, 0, cx);
    drv(0, 0, 16'h0, 1, 1, 16'h0041, 16'h5555, 0, cx);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    // Reset during an access; starvation count restarts afterwards.
    drv(1, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 0, c6);
    drv(0, 1, 16'h0006, 1, 0, 16'h0008, 16'h0, 0, c7);
    for (int k = 1; k < 4; k++) drv(0, 1, 16'h0006, 1, 0, 16'h0008, 16'h0, 0, cx);
    // Halt with a pending write.
    drv(0, 1, 16'h0000, 1, 1, 16'h0020, 16'hCAFE, 1, c8);
    drv(0, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 1, c9);
    drv(0, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 1, cx);
    drv(0, 1, 16'h0000, 0, 0, 16'h0, 16'h0, 1, cx);
    drv(0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0, 0, cx);
    drv(1, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);
    drv(0, 1, 16'h0020, 0, 0, 16'h0, 16'h0, 0, c10);
    drv(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, cx);

    // Hand-computed spot checks.
    chk("rst_if_done", 16'(t_ifd[c0 + 1]), 16'h0);
    chk("rst_halted", 16'(t_halted[c0 + 1]), 16'h0);
    chk("fetch_gnt", 16'(t_ifg[c1]), 16'h1);
    chk("fetch_done", 16'(t_ifd[c1 + 1]), 16'h1);
    chk("fetch_rdata", t_ifr[c1 + 1], 16'h1234);
    chk("fetch_err", 16'(t_ife[c1 + 1]), 16'h0);
    chk("wr_done_rdata", t_dmr[c2 + 1], 16'h0000);
    chk("wr_done", 16'(t_dmd[c2 + 1]), 16'h1);
    chk("rd_back", t_dmr[c3 + 1], 16'hBEEF);
    for (int k = 0; k < 6; k++) begin
      chk("starve_ifg", 16'(t_ifg[c4 + k]), 16'(k == 3));
      chk("starve_dmg", 16'(t_dmg[c4 + k]), 16'(k != 3));
    end
    chk("ua_gnt", 16'(t_dmg[c5]), 16'h1);
    chk("ua_en", 16'(t_en[c5]), 16'h0);
    chk("ua_err", 16'(t_dme[c5 + 1]), 16'h1);
    chk("ua_rdata", t_dmr[c5 + 1], 16'h0000);
    chk("ua_err_clr", 16'(t_dme[c5 + 2]), 16'h0);
    chk("rst_done_sup", 16'(t_ifd[c6 + 1]), 16'h0);
    chk("rst_rdata", t_ifr[c6 + 1], 16'h0000);
    chk("post_rst_ifg", 16'(t_ifg[c7 + 3]), 16'h1);
    chk("post_rst_dmg", 16'(t_dmg[c7 + 2]), 16'h1);
    chk("halt_wr_gnt", 16'(t_dmg[c8]), 16'h1);
    chk("halt_no_gnt", 16'(t_ifg[c9] | t_dmg[c9]), 16'h0);
    chk("dump_pulse", 16'(t_dump[c9 + 1]), 16'h1);
    chk("dump_once", 16'(t_dump[c9 + 2]), 16'h0);
    chk("halted_on", 16'(t_halted[c9 + 2]), 16'h1);
    chk("halted_no_if", 16'(t_ifg[c9 + 3]), 16'h0);
    chk("halted_stays", 16'(t_halted[c9 + 4]), 16'h1);
    chk("halt_wr_mem", {env_mem[8'h20], env_mem[8'h21]}, 16'hCAFE);
    chk("rerun_rdata", t_ifr[c10 + 1], 16'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
